aib_cfg_avmm_master: RTL

//  Synthesizable single-outstanding Avalon-MM master that drives the AIB adapter configuration

---
 rtl/aib_cfg_avmm_master.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/aib_cfg_avmm_master.sv
// Single-outstanding Avalon-MM master for the AIB adapter cfg port.
// One command in, one AVMM transfer with waitrequest/readdatavalid, one response out.
module aib_cfg_avmm_master #(
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  i_cfg_avmm_clk,
    input  logic                  i_cfg_avmm_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_write,
    input  logic [ADDR_W-1:0]     i_cmd_addr,
    input  logic [DATA_W/8-1:0]   i_cmd_byte_en,
    input  logic [DATA_W-1:0]     i_cmd_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic                  o_rsp_write,
    output logic [DATA_W-1:0]     o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic [ADDR_W-1:0]     o_cfg_avmm_addr,
    output logic [DATA_W/8-1:0]   o_cfg_avmm_byte_en,
    output logic [DATA_W-1:0]     o_cfg_avmm_wdata,
    output logic                  o_cfg_avmm_write,
    output logic                  o_cfg_avmm_read,
    input  logic                  i_cfg_avmm_waitreq,
    input  logic                  i_cfg_avmm_rdatavld,
    input  logic [DATA_W-1:0]     i_cfg_avmm_rdata,
    output logic                  o_busy
);

    localparam int          BE_W     = DATA_W / 8;
    localparam logic [16:0] TMO_LAST = 17'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RDWAIT,
        ST_RESP
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [16:0]         r_tmo_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [BE_W-1:0]     r_byte_en;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_write;
    logic                r_read;
    logic                r_rsp_write;
    logic                r_rsp_err;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                w_accept;
    logic                w_tmo_hit;
    logic                w_cap_rdata;
    logic                w_abort;
    logic                w_in_xfer;
    logic                w_strobe_end;
    logic                w_enter_resp;

    assign o_cmd_ready  = (r_state == ST_IDLE) & ~i_cfg_avmm_rst;
    assign w_accept     = i_cmd_valid & o_cmd_ready;
    assign w_tmo_hit    = (r_tmo_cnt >= TMO_LAST);
    assign w_in_xfer    = (r_state == ST_WR) | (r_state == ST_RD) | (r_state == ST_RDWAIT);
    assign w_strobe_end = ((r_state == ST_WR) | (r_state == ST_RD)) & (w_state_next != r_state);
    assign w_enter_resp = (w_state_next == ST_RESP) & (r_state != ST_RESP);

    always_ff @(posedge i_cfg_avmm_clk) begin
        if (i_cfg_avmm_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A completing handshake is tested before the timeout so it wins a tie.
    always_comb begin
        w_state_next = r_state;
        w_cap_rdata  = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = i_cmd_write ? ST_WR : ST_RD;
                end
            end
            ST_WR: begin
                if (!i_cfg_avmm_waitreq) begin
                    w_state_next = ST_RESP;
                end else if (w_tmo_hit) begin
                    w_state_next = ST_RESP;
                    w_abort      = 1'b1;
                end
            end
            ST_RD: begin
                if (!i_cfg_avmm_waitreq) begin
                    if (i_cfg_avmm_rdatavld) begin
                        w_state_next = ST_RESP;
                        w_cap_rdata  = 1'b1;
                    end else begin
                        w_state_next = ST_RDWAIT;
                    end
                end else if (w_tmo_hit) begin
                    w_state_next = ST_RESP;
                    w_abort      = 1'b1;
                end
            end
            ST_RDWAIT: begin
                if (i_cfg_avmm_rdatavld) begin
                    w_state_next = ST_RESP;
                    w_cap_rdata  = 1'b1;
                end else if (w_tmo_hit) begin
                    w_state_next = ST_RESP;
                    w_abort      = 1'b1;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_cfg_avmm_clk) begin
        if (i_cfg_avmm_rst) begin
            r_tmo_cnt   <= '0;
            r_addr      <= '0;
            r_byte_en   <= '0;
            r_wdata     <= '0;
            r_write     <= 1'b0;
            r_read      <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_addr      <= i_cmd_addr;
                r_byte_en   <= i_cmd_byte_en;
                r_wdata     <= i_cmd_wdata;
                r_write     <= i_cmd_write;
                r_read      <= ~i_cmd_write;
                r_rsp_write <= i_cmd_write;
                r_tmo_cnt   <= '0;
            end else if (w_in_xfer) begin
                r_tmo_cnt <= r_tmo_cnt + 17'd1;
            end
            if (w_strobe_end) begin
                r_write <= 1'b0;
                r_read  <= 1'b0;
            end
            if (w_enter_resp) begin
                r_rsp_rdata <= w_cap_rdata ? i_cfg_avmm_rdata : '0;
                r_rsp_err   <= w_abort;
            end
        end
    end

    assign o_rsp_valid        = (r_state == ST_RESP);
    assign o_rsp_write        = r_rsp_write;
    assign o_rsp_rdata        = r_rsp_rdata;
    assign o_rsp_err          = r_rsp_err;
    assign o_cfg_avmm_addr    = r_addr;
    assign o_cfg_avmm_byte_en = r_byte_en;
    assign o_cfg_avmm_wdata   = r_wdata;
    assign o_cfg_avmm_write   = r_write;
    assign o_cfg_avmm_read    = r_read;
    assign o_busy             = (r_state != ST_IDLE);

endmodule
